// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter that gives one shared datapath slice (the gate/ALU
// resource) to one of NUM_REQ requesters at a time. A grant is held until the
// owner raises its done bit or drops its req bit. Every grant is followed by
// at least one idle cycle. The search for the next owner starts just after
// the previous owner, so every requester gets served in turn.
//
// Optional feature: define ARB_WATCHDOG_EN to build a hold watchdog. If an
// owner keeps the grant for HOLD_MAX cycles, the watchdog takes the grant
// away and pulses timeout for one cycle. Without the macro, timeout is tied
// to 0 and a grant is held for as long as the owner wants.
//
// Ports
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous active-low reset
//   req       in   NUM_REQ  level request, one bit per requester
//   done      in   NUM_REQ  release strobe; only the owner's bit is honoured
//   grant     out  NUM_REQ  registered one-hot grant, all zero when idle
//   grant_id  out  ID_W     binary index of the owner, valid while busy=1
//   busy      out  1        high while a grant is held
//   timeout   out  1        one-cycle pulse on a watchdog forced release
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } arbState_t;

    arbState_t          state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [ID_W-1:0]    grantId_q;
    logic [ID_W-1:0]    lastIdx_q;
    logic               busy_q;

    logic               pickValid;
    logic [ID_W-1:0]    pickIdx;
    logic               ownerRelease;

    // The search runs from the highest offset down to the lowest. Each hit
    // overwrites the one before, so the requester closest after lastIdx_q
    // wins. The previous owner is at offset NUM_REQ, so it only wins when
    // no other bit is set.
    always_comb begin
        int cand;
        pickValid = 1'b0;
        pickIdx   = '0;
        cand      = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = (int'(lastIdx_q) + i) % NUM_REQ;
            if (req[cand[ID_W-1:0]]) begin
                pickValid = 1'b1;
                pickIdx   = cand[ID_W-1:0];
            end
        end
    end

    // Only the owner's own bits count. Activity on other bits is ignored.
    assign ownerRelease = done[grantId_q] | ~req[grantId_q];

`ifdef ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(HOLD_MAX) + 1;
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] holdCnt_q;
    logic             timeout_q;

    // Arbiter FSM with a watchdog. A normal release is checked before the
    // limit, so a release that falls on the same cycle as the limit does
    // not raise timeout. A forced release leaves lastIdx_q on the offender,
    // so the offender gets the lowest priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            grantId_q <= '0;
            lastIdx_q <= ID_W'(NUM_REQ - 1);
            busy_q    <= 1'b0;
            holdCnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pickValid) begin
                        state_q   <= GRANT;
                        grant_q   <= NUM_REQ'(1) << pickIdx;
                        grantId_q <= pickIdx;
                        lastIdx_q <= pickIdx;
                        busy_q    <= 1'b1;
                        holdCnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (ownerRelease) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (holdCnt_q == HOLD_LIMIT) begin
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        holdCnt_q <= holdCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign timeout = timeout_q;
`else
    // Arbiter FSM without a watchdog. grant_id keeps its value after a
    // release, so the resource mux select does not change while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            grantId_q <= '0;
            lastIdx_q <= ID_W'(NUM_REQ - 1);
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickValid) begin
                        state_q   <= GRANT;
                        grant_q   <= NUM_REQ'(1) << pickIdx;
                        grantId_q <= pickIdx;
                        lastIdx_q <= pickIdx;
                        busy_q    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (ownerRelease) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign timeout = 1'b0;
`endif

    assign grant    = grant_q;
    assign grant_id = grantId_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
// Self-checking bench for rr_arbiter. Inputs are driven on the falling edge.
// When the bench drives an input, a reference model works out the outputs
// the arbiter should show after the next rising edge. These expected values
// go into a queue. A monitor takes them off the queue and compares them with
// the DUT just after the rising edge. Directed checks with fixed values cover
// the named scenarios.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;

    localparam int N = 4;
    localparam int W = 2;
    localparam int H = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic [W-1:0] grant_id;
    logic         busy;
    logic         timeout;

    typedef struct packed {
        logic [N-1:0] g;
        logic [W-1:0] id;
        logic         b;
        logic         t;
    } expect_t;

    expect_t expQ[$];
    int      checkCount;
    int      errorCount;

    // Reference model state
    int           mState;
    int           mLast;
    int           mCnt;
    logic [N-1:0] mGrant;
    logic [W-1:0] mId;
    logic         mBusy;
    logic         mTo;

    rr_arbiter #(
        .NUM_REQ (N),
        .ID_W    (W),
        .HOLD_MAX(H)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .grant_id(grant_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared comparison: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mState = 0;
        mLast  = N - 1;
        mCnt   = 0;
        mGrant = '0;
        mId    = '0;
        mBusy  = 1'b0;
        mTo    = 1'b0;
    endtask

    // Works out the outputs the arbiter should show after the next rising edge.
    task automatic modelStep(input logic [N-1:0] r, input logic [N-1:0] d);
        bit found;
        int pick;
        found = 0;
        pick  = 0;
        mTo   = 1'b0;
        if (mState == 0) begin
            for (int i = 1; i <= N; i++) begin
                if (!found && r[(mLast + i) % N]) begin
                    found = 1;
                    pick  = (mLast + i) % N;
                end
            end
            if (found) begin
                mState = 1;
                mGrant = N'(1) << pick;
                mId    = W'(pick);
                mBusy  = 1'b1;
                mLast  = pick;
                mCnt   = 0;
            end
        end else begin
            if (d[mId] || !r[mId]) begin
                mState = 0;
                mGrant = '0;
                mBusy  = 1'b0;
            end
`ifdef ARB_WATCHDOG_EN
            else if (mCnt == H - 1) begin
                mState = 0;
                mGrant = '0;
                mBusy  = 1'b0;
                mTo    = 1'b1;
            end
`endif
            else begin
                mCnt++;
            end
        end
    endtask

    // Call this at a falling edge. It drives req and done, queues the
    // expected result, and returns at the next falling edge.
    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] d);
        expect_t e;
        req  = r;
        done = d;
        modelStep(r, d);
        e.g  = mGrant;
        e.id = mId;
        e.b  = mBusy;
        e.t  = mTo;
        expQ.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: takes one expected entry per rising edge and compares it.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("sb_grant",    32'(grant),    32'(e.g));
                checkOutput("sb_grant_id", 32'(grant_id), 32'(e.id));
                checkOutput("sb_busy",     32'(busy),     32'(e.b));
                checkOutput("sb_timeout",  32'(timeout),  32'(e.t));
            end
        end
    end

    initial begin
        logic [N-1:0] order [4];
        logic [N-1:0] rr;
        logic [N-1:0] dd;
        checkCount = 0;
        errorCount = 0;
        order[0] = 4'b0010;
        order[1] = 4'b0100;
        order[2] = 4'b1000;
        order[3] = 4'b0001;

        // 1: reset while every requester is asking
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 4'b0000;
        modelReset();
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_grant",   32'(grant),   32'h0);
        checkOutput("reset_busy",    32'(busy),    32'h0);
        checkOutput("reset_timeout", 32'(timeout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1111, 4'b0000);
        checkOutput("first_grant", 32'(grant), 32'h1);

        // 2: fairness with all four requesting. Each owner pulses done two
        // cycles after its grant.
        for (int n = 0; n < 4; n++) begin
            applyStimulus(4'b1111, 4'b0000);
            applyStimulus(4'b1111, grant);
            checkOutput("fair_idle_gap", 32'(grant), 32'h0);
            applyStimulus(4'b1111, 4'b0000);
            checkOutput("fair_order", 32'(grant), 32'(order[n]));
        end

        // 3: release when req drops; a non-owner done is ignored
        applyStimulus(4'b1111, 4'b0001);
        applyStimulus(4'b1100, 4'b0000);
        checkOutput("drop_grant2", 32'(grant), 32'b0100);
        applyStimulus(4'b1110, 4'b0010);
        checkOutput("nonowner_done", 32'(grant), 32'b0100);
        applyStimulus(4'b1010, 4'b0000);
        checkOutput("drop_release", 32'(grant), 32'h0);

        // 4: two requests at once with last=1
        applyStimulus(4'b0010, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        applyStimulus(4'b1010, 4'b0000);
        checkOutput("simul_grant", 32'(grant),    32'b1000);
        checkOutput("simul_id",    32'(grant_id), 32'd3);
        applyStimulus(4'b0010, 4'b0000);
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("simul_next", 32'(grant), 32'b0010);

        // 5: asynchronous reset in the middle of a grant
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_grant", 32'(grant), 32'h0);
        checkOutput("async_rst_busy",  32'(busy),  32'h0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0011, 4'b0000);
        checkOutput("post_rst_grant", 32'(grant), 32'b0001);

        // 6: owner 0 never releases
`ifdef ARB_WATCHDOG_EN
        for (int j = 1; j <= H + 1; j++) begin
            applyStimulus(4'b0011, 4'b0000);
            if (j == H - 1) checkOutput("wd_still_held", 32'(grant), 32'b0001);
            if (j == H) begin
                checkOutput("wd_dropped", 32'(grant),   32'h0);
                checkOutput("wd_timeout", 32'(timeout), 32'h1);
            end
            if (j == H + 1) begin
                checkOutput("wd_next_owner", 32'(grant),   32'b0010);
                checkOutput("wd_pulse_end",  32'(timeout), 32'h0);
            end
        end
`else
        for (int j = 1; j <= 100; j++) begin
            applyStimulus(4'b0011, 4'b0000);
        end
        checkOutput("hold_100",       32'(grant),   32'b0001);
        checkOutput("hold_100_no_to", 32'(timeout), 32'h0);
`endif

        // Random traffic, checked only through the scoreboard
        for (int j = 0; j < 300; j++) begin
            rr = N'($urandom_range(0, (1 << N) - 1));
            dd = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            applyStimulus(rr, dd);
        end

        @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            checkOutput("sb_drained", 32'(expQ.size()), 32'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
